prog_loader: RTL
================

# prog_loader

Serial program loader that writes the instruction memory of the tiny processor from the input switches. Instructions are entered as nibble strobes on external pins, assembled into 8-bit instructions, and written sequentially into imem. Locations past the program end are zero-filled. The core is held while loading and restarted when loading finishes. The block sits between the top-level pins and the imem write port, and is the write-side counterpart of the core's instruction fetch.

## Interface
- IMEM_SZ, 16, instruction memory depth; address width is 4.
- INST_W, 8, instruction width; must be 2 nibbles.
- SYNC_STAGES, 2, number of synchronizer flops on each strobe input.

- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- start_in  in  1  asynchronous level from a pin; a rising edge requests a load.
- nib_stb_in  in  1  asynchronous level from a pin; a rising edge presents one nibble.
- nib_in  in  4  nibble data; must be stable from 1 cycle before the nib_stb_in rise until nib_stb_in falls.
- imem_wen_out  out  1  imem write enable, one cycle per write.
- imem_waddr_out  out  4  imem write address.
- imem_wdata_out  out  8  imem write data, {hi nibble, lo nibble}.
- core_hold_out  out  1  freezes pc, acc and dmem writes while high.
- core_restart_out  out  1  one-cycle pulse; the core clears pc, acc and dmem, but not imem.
- busy_out  out  1  high from load acceptance until restart.
- addr_out  out  4  current write address, for the seven-segment status display.

## Operation
- Synchronizer: each strobe input passes through SYNC_STAGES flops plus one edge flop. A strobe is accepted on the cycle where the synchronized value is 1 and the delayed value is 0. nib_in is captured in that same cycle.
- States and transitions:
  - IDLE: accepted start → HDR. Nibble strobes are ignored.
  - HDR: accepted nibble sets last = nib_in, addr = 0 → LO.
  - LO: accepted nibble is latched as lo (the opcode field, inst[3:0]) → HI.
  - HI: accepted nibble is latched as hi (operand field, inst[7:4]) → WR.
  - WR: imem_wen = 1, waddr = addr, wdata = {hi, lo}. Then:
    - if addr == last and last == 15 → DONE;
    - if addr == last and last < 15 → FILL with addr = last + 1;
    - otherwise addr = addr + 1 → LO.
  - FILL: one write per cycle with wdata = 8'h00 at addr. If addr == 15 → DONE; otherwise addr = addr + 1. The address never wraps.
  - DONE: core_restart_out = 1 for this cycle only → IDLE.
- Outputs by state:
  - core_hold_out = 1 in HDR, LO, HI, WR, FILL and DONE.
  - busy_out = core_hold_out.
- Header 0 loads exactly one instruction at address 0, then zero-fills addresses 1..15.
- Start strobes accepted outside IDLE are ignored. Nibble strobes accepted in WR, FILL or DONE are dropped; this cannot happen at human strobe rates.
- Address width rule: addr is 4 bits. Comparisons are done at 4 bits. No 5th bit is needed because FILL stops at 15.

## Timing
- Reset values:
  - state IDLE; addr, last, lo, hi = 0; all synchronizer flops = 0.
  - imem_wen_out = 0, imem_waddr_out = 0, imem_wdata_out = 0.
  - core_hold_out = 0, core_restart_out = 0, busy_out = 0, addr_out = 0.
- Acceptance latency: a pin rise is accepted SYNC_STAGES + 1 cycles after the first clk edge that samples it high.
- core_hold_out rises on the cycle after start is accepted.
- The imem write occurs 1 cycle after the hi nibble is accepted.
- The zero-fill takes 15 − last cycles. DONE follows the final write by 1 cycle.
- Outputs are registered; no output has a combinational path from any input.
- Reset mid-load: state returns to IDLE and hold drops on the next edge. imem keeps any partial contents. No restart pulse is issued.
- Simultaneous start and nibble acceptance in IDLE: start wins and the nibble is ignored.

## Structure
- Shared package `tp_pkg`:
  - IMEM_SZ, INST_W, DATAPATH_W and the CLOG2 macro (PC_W derives from it).
  - Loader state encoding enum: IDLE, HDR, LO, HI, WR, FILL, DONE.
- Sub-module `pin_sync_edge`, instantiated twice (start, nibble strobe): SYNC_STAGES flops plus a rising-edge pulse output.

## Test plan
- Reset with all inputs 0 → all outputs 0 and state IDLE; 20 idle cycles produce no imem writes.
- Start, header 0x2, then nibbles B,5 / 7,0 / B,1 → writes 5B@0, 07@1, 1B@2, then 00@3..15 on consecutive cycles; one restart pulse; hold high throughout.
- Header 0xF with 32 nibbles → 16 writes, no FILL cycles, restart 1 cycle after the write to address 15.
- Strobe pulse held only SYNC_STAGES−1 cycles versus held ≥ SYNC_STAGES+1 cycles → the short pulse is not guaranteed to be accepted, and is never accepted twice; the long pulse is accepted exactly once.
- Reset asserted after the header and 3 nibbles → next cycle state is IDLE, hold 0, no restart; a subsequent full load succeeds.
- Start strobe during LO, and nibble strobe during IDLE → both ignored; the write sequence is unchanged.

Source files
------------

// File: rtl/tp_pkg.sv
// Shared definitions for the tiny processor: memory geometry and the
// program loader's state encoding.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package tp_pkg;

  localparam int IMEM_SZ    = 16;
  localparam int INST_W     = 8;
  localparam int DATAPATH_W = 8;
  localparam int PC_W       = `CLOG2(IMEM_SZ);
  localparam int NIB_W      = INST_W / 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LO   = 3'd2,
    ST_HI   = 3'd3,
    ST_WR   = 3'd4,
    ST_FILL = 3'd5,
    ST_DONE = 3'd6
  } ld_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Pin-side strobes and imem/core-control signals of the program loader.
interface prog_loader_if;
  import tp_pkg::*;

  logic              start_in;
  logic              nib_stb_in;
  logic [NIB_W-1:0]  nib_in;
  logic              imem_wen_out;
  logic [PC_W-1:0]   imem_waddr_out;
  logic [INST_W-1:0] imem_wdata_out;
  logic              core_hold_out;
  logic              core_restart_out;
  logic              busy_out;
  logic [PC_W-1:0]   addr_out;

  modport slave (
    input  start_in, nib_stb_in, nib_in,
    output imem_wen_out, imem_waddr_out, imem_wdata_out,
           core_hold_out, core_restart_out, busy_out, addr_out
  );

  modport master (
    output start_in, nib_stb_in, nib_in,
    input  imem_wen_out, imem_waddr_out, imem_wdata_out,
           core_hold_out, core_restart_out, busy_out, addr_out
  );

endinterface

// File: rtl/pin_sync_edge.sv
// Synchronizes an asynchronous pin level and flags its rising edge.
// SYNC_STAGES must be at least 2.
module pin_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  // One-cycle pulse per synchronized low-to-high transition.
  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: assembles nibble strobes into instructions, writes
// them into imem, zero-fills the tail and restarts the core.
module prog_loader
  import tp_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_HDR  = ST_HDR;
  localparam logic [2:0] S_LO   = ST_LO;
  localparam logic [2:0] S_HI   = ST_HI;
  localparam logic [2:0] S_WR   = ST_WR;
  localparam logic [2:0] S_FILL = ST_FILL;
  localparam logic [2:0] S_DONE = ST_DONE;

  localparam logic [PC_W-1:0] ADDR_MAX = PC_W'(IMEM_SZ - 1);
  localparam logic [PC_W-1:0] ADDR_ONE = PC_W'(1);

  logic start_acc;
  logic nib_acc;

  logic [2:0]       state_q, state_n;
  logic [PC_W-1:0]  addr_q,  addr_n;
  logic [PC_W-1:0]  last_q,  last_n;
  logic [NIB_W-1:0] lo_q,    lo_n;
  logic [NIB_W-1:0] hi_q,    hi_n;

  logic              wen_q;
  logic [PC_W-1:0]   waddr_q;
  logic [INST_W-1:0] wdata_q;
  logic              hold_q;
  logic              restart_q;
  logic [PC_W-1:0]   addr_disp_q;

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (bus.start_in),
    .rise (start_acc)
  );

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nib_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (bus.nib_stb_in),
    .rise (nib_acc)
  );

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    last_n  = last_q;
    lo_n    = lo_q;
    hi_n    = hi_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) state_n = S_HDR;
      end
      S_HDR: begin
        if (nib_acc) begin
          last_n  = PC_W'(bus.nib_in);
          addr_n  = '0;
          state_n = S_LO;
        end
      end
      S_LO: begin
        if (nib_acc) begin
          lo_n    = bus.nib_in;
          state_n = S_HI;
        end
      end
      S_HI: begin
        if (nib_acc) begin
          hi_n    = bus.nib_in;
          state_n = S_WR;
        end
      end
      S_WR: begin
        if (addr_q == last_q) begin
          if (last_q == ADDR_MAX) begin
            state_n = S_DONE;
          end else begin
            addr_n  = last_q + ADDR_ONE;
            state_n = S_FILL;
          end
        end else begin
          addr_n  = addr_q + ADDR_ONE;
          state_n = S_LO;
        end
      end
      S_FILL: begin
        // The address stops at the top of imem; it never wraps.
        if (addr_q == ADDR_MAX) state_n = S_DONE;
        else                    addr_n  = addr_q + ADDR_ONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // reflects the state it belongs to without a path from the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      hold_q      <= 1'b0;
      restart_q   <= 1'b0;
      addr_disp_q <= '0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      last_q      <= last_n;
      lo_q        <= lo_n;
      hi_q        <= hi_n;
      wen_q       <= (state_n == S_WR) || (state_n == S_FILL);
      waddr_q     <= addr_n;
      wdata_q     <= (state_n == S_WR) ? {hi_n, lo_n} : '0;
      hold_q      <= (state_n != S_IDLE);
      restart_q   <= (state_n == S_DONE);
      addr_disp_q <= addr_n;
    end
  end

  assign bus.imem_wen_out     = wen_q;
  assign bus.imem_waddr_out   = waddr_q;
  assign bus.imem_wdata_out   = wdata_q;
  assign bus.core_hold_out    = hold_q;
  assign bus.core_restart_out = restart_q;
  assign bus.busy_out         = hold_q;
  assign bus.addr_out         = addr_disp_q;

endmodule
